serial_frame_arbiter: RTL and testbench



---
 rtl/serial_frame_arbiter.sv | 173 +++++++++++++++++
 tb/tb_serial_frame_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_arbiter.sv
// Round-robin arbiter for two requesters driving one serial command link (cmd, addr, data MSB-first).
// Define SERIAL_PARITY_EN to append an even-parity bit over address+data after the data field.
module serial_frame_arbiter #(
  parameter int BIT_CYCLES = 2,
  parameter int GAP_BITS   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [5:0] req0_addr,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [5:0] req1_addr,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       out_flow,
  output logic       busy,
  output logic       grant_id,
  output logic       frame_done
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, PAR, GAP} state_t;

  localparam logic [2:0] CMD_WORD = 3'b110;
  localparam logic [3:0] LAST_CYC = 4'(BIT_CYCLES - 1);
  localparam logic [3:0] LAST_GAP = 4'(GAP_BITS - 1);

  state_t      state_q;
  logic [13:0] shift_q;
  logic [3:0]  bitCnt_q;
  logic [3:0]  idx_q;
  logic        ptr_q;
  logic        grant_q;
  logic        out_q;
`ifdef SERIAL_PARITY_EN
  logic        parity_q;
`endif

  logic grant0, grant1, idle, accept, bitWrap;

  // ptr_q = 1 means req1 is favoured when both requesters are valid.
  assign grant0     = req0_valid & (~req1_valid | ~ptr_q);
  assign grant1     = req1_valid & (~req0_valid | ptr_q);
  assign idle       = (state_q == IDLE);
  assign req0_ready = idle & grant0 & ~rst;
  assign req1_ready = idle & grant1 & ~rst;
  assign accept     = req0_ready | req1_ready;
  assign bitWrap    = (bitCnt_q == LAST_CYC);

  assign out_flow = out_q;
  assign busy     = ~idle;
  assign grant_id = grant_q;
`ifdef SERIAL_PARITY_EN
  assign frame_done = (state_q == PAR) & bitWrap;
`else
  assign frame_done = (state_q == DATA) & (idx_q == 4'd7) & bitWrap;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      bitCnt_q <= '0;
      idx_q    <= '0;
      ptr_q    <= 1'b0;
      grant_q  <= 1'b0;
      out_q    <= 1'b0;
`ifdef SERIAL_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          out_q    <= 1'b0;
          bitCnt_q <= '0;
          idx_q    <= '0;
          if (accept) begin
            shift_q <= req1_ready ? {req1_addr, req1_data} : {req0_addr, req0_data};
            grant_q <= req1_ready;
            ptr_q   <= ~req1_ready;
`ifdef SERIAL_PARITY_EN
            parity_q <= req1_ready ? ^{req1_addr, req1_data} : ^{req0_addr, req0_data};
`endif
            out_q   <= CMD_WORD[2];
            state_q <= CMD;
          end
        end
        CMD: begin
          if (bitWrap) begin
            bitCnt_q <= '0;
            if (idx_q == 4'd2) begin
              idx_q   <= '0;
              out_q   <= shift_q[13];
              state_q <= ADDR;
            end else begin
              idx_q <= idx_q + 4'd1;
              out_q <= (idx_q == 4'd0) ? CMD_WORD[1] : CMD_WORD[0];
            end
          end else begin
            bitCnt_q <= bitCnt_q + 4'd1;
          end
        end
        ADDR: begin
          if (bitWrap) begin
            bitCnt_q <= '0;
            shift_q  <= {shift_q[12:0], 1'b0};
            out_q    <= shift_q[12];
            if (idx_q == 4'd5) begin
              idx_q   <= '0;
              state_q <= DATA;
            end else begin
              idx_q <= idx_q + 4'd1;
            end
          end else begin
            bitCnt_q <= bitCnt_q + 4'd1;
          end
        end
        DATA: begin
          if (bitWrap) begin
            bitCnt_q <= '0;
            shift_q  <= {shift_q[12:0], 1'b0};
            if (idx_q == 4'd7) begin
              idx_q <= '0;
`ifdef SERIAL_PARITY_EN
              out_q   <= parity_q;
              state_q <= PAR;
`else
              out_q   <= 1'b0;
              state_q <= (GAP_BITS == 0) ? IDLE : GAP;
`endif
            end else begin
              idx_q <= idx_q + 4'd1;
              out_q <= shift_q[12];
            end
          end else begin
            bitCnt_q <= bitCnt_q + 4'd1;
          end
        end
`ifdef SERIAL_PARITY_EN
        PAR: begin
          if (bitWrap) begin
            bitCnt_q <= '0;
            out_q    <= 1'b0;
            state_q  <= (GAP_BITS == 0) ? IDLE : GAP;
          end else begin
            bitCnt_q <= bitCnt_q + 4'd1;
          end
        end
`endif
        GAP: begin
          out_q <= 1'b0;
          if (bitWrap) begin
            bitCnt_q <= '0;
            if (idx_q == LAST_GAP) begin
              idx_q   <= '0;
              state_q <= IDLE;
            end else begin
              idx_q <= idx_q + 4'd1;
            end
          end else begin
            bitCnt_q <= bitCnt_q + 4'd1;
          end
        end
        default: begin
          out_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_arbiter.sv
// Self-checking bench for serial_frame_arbiter: scoreboard of expected frames, one task per scenario.
// Build with SERIAL_PARITY_EN defined to exercise the 18-bit parity frame.
module tb_serial_frame_arbiter;

  localparam int BC  = 2;
  localparam int GAP = 1;
`ifdef SERIAL_PARITY_EN
  localparam int FRAME_BITS = 18;
`else
  localparam int FRAME_BITS = 17;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [5:0] req0_addr = '0, req1_addr = '0;
  logic [7:0] req0_data = '0, req1_data = '0;
  logic       req0_ready, req1_ready, out_flow, busy, grant_id, frame_done;

  typedef struct {
    logic       id;
    logic [5:0] addr;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    logic        id;
    logic [17:0] bits;
    int          doneAt;
    int          doneCount;
    int          waitCycles;
    bit          bothReady;
    bit          bad;
    bit          accepted;
  } obs_t;

  exp_t sbQ[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  serial_frame_arbiter #(.BIT_CYCLES(BC), .GAP_BITS(GAP)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .out_flow(out_flow), .busy(busy), .grant_id(grant_id), .frame_done(frame_done)
  );

  // Reference frame: command 110, address, data, then even parity when enabled.
  function automatic logic [17:0] expBits(input logic [5:0] a, input logic [7:0] d);
`ifdef SERIAL_PARITY_EN
    return {3'b110, a, d, ^{a, d}};
`else
    return {1'b0, 3'b110, a, d};
`endif
  endfunction

  // Drive requester inputs just after a rising edge so the next falling-edge sample sees them.
  task automatic applyStimulus(input logic v0, input logic [5:0] a0, input logic [7:0] d0,
                               input logic v1, input logic [5:0] a1, input logic [7:0] d1);
    @(posedge clk);
    #1;
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
  endtask

  // Wait for an accept, then sample one full frame plus its gap on falling edges.
  task automatic captureFrame(input bit clobber, output obs_t o);
    int b;
    o.id = 1'b0; o.bits = '0; o.doneAt = -1; o.doneCount = 0; o.waitCycles = 0;
    o.bothReady = 1'b0; o.bad = 1'b0; o.accepted = 1'b0;
    while (!o.accepted && o.waitCycles < 200) begin
      @(negedge clk);
      o.waitCycles++;
      if (req0_ready === 1'b1 && req1_ready === 1'b1) o.bothReady = 1'b1;
      if ((req0_valid && req0_ready === 1'b1) || (req1_valid && req1_ready === 1'b1)) begin
        o.accepted = 1'b1;
        o.id = req1_ready;
      end
    end
    checks++;
    if (!o.accepted) begin
      errors++;
      $display("[TB] FAIL accept_timeout: got no accept after %0d cycles, want an accept", o.waitCycles);
      return;
    end
    if (clobber) begin
      @(posedge clk);
      #1;
      req0_data = 8'h00;
    end
    for (int k = 1; k <= FRAME_BITS * BC; k++) begin
      @(negedge clk);
      b = (k - 1) / BC;
      if ((k - 1) % BC == 0) o.bits[FRAME_BITS - 1 - b] = out_flow;
      else if (out_flow !== o.bits[FRAME_BITS - 1 - b]) o.bad = 1'b1;
      if (busy !== 1'b1) o.bad = 1'b1;
      if (frame_done === 1'b1) begin
        o.doneCount++;
        o.doneAt = k;
      end
    end
    for (int k = 0; k < GAP * BC; k++) begin
      @(negedge clk);
      if (out_flow !== 1'b0 || busy !== 1'b1 || frame_done !== 1'b0) o.bad = 1'b1;
    end
  endtask

  task automatic test_reset;
    exp_t e;
    obs_t o;
    rst = 1'b1;
    req0_valid = 1'b1; req0_addr = 6'h15; req0_data = 8'h3C;
    req1_valid = 1'b1; req1_addr = 6'h2A; req1_data = 8'hC3;
    sbQ.push_back('{1'b0, 6'h15, 8'h3C});
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (out_flow !== 1'b0 || busy !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0 ||
          frame_done !== 1'b0 || grant_id !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset.outputs: got out=%b busy=%b rdy=%b%b done=%b gid=%b, want all 0",
                 out_flow, busy, req0_ready, req1_ready, frame_done, grant_id);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    captureFrame(1'b0, o);
    req0_valid = 1'b0; req1_valid = 1'b0;
    e = sbQ.pop_front();
    checks++;
    if (o.id !== e.id) begin
      errors++; $display("[TB] FAIL reset.first_grant: got %b want %b", o.id, e.id);
    end
    checks++;
    if (o.bothReady) begin
      errors++; $display("[TB] FAIL reset.one_ready: got both ready, want exactly one");
    end
    checks++;
    if (o.bits !== expBits(e.addr, e.data)) begin
      errors++; $display("[TB] FAIL reset.bits: got %h want %h", o.bits, expBits(e.addr, e.data));
    end
  endtask

  task automatic test_single_frame;
    exp_t e;
    obs_t o;
    applyStimulus(1'b1, 6'h2D, 8'hA7, 1'b0, 6'h00, 8'h00);
    sbQ.push_back('{1'b0, 6'h2D, 8'hA7});
    captureFrame(1'b0, o);
    req0_valid = 1'b0;
    e = sbQ.pop_front();
    checks++;
    if (o.bits !== expBits(e.addr, e.data)) begin
      errors++; $display("[TB] FAIL single.bits: got %h want %h", o.bits, expBits(e.addr, e.data));
    end
    checks++;
    if (o.doneAt !== FRAME_BITS * BC || o.doneCount !== 1) begin
      errors++;
      $display("[TB] FAIL single.frame_done: got cycle %0d count %0d, want cycle %0d count 1",
               o.doneAt, o.doneCount, FRAME_BITS * BC);
    end
    checks++;
    if (o.bad) begin
      errors++; $display("[TB] FAIL single.hold_gap: got unstable bit, busy drop or gap activity, want clean frame");
    end
    checks++;
    if (grant_id !== e.id || o.id !== e.id) begin
      errors++; $display("[TB] FAIL single.grant_id: got %b/%b want %b", grant_id, o.id, e.id);
    end
  endtask

  task automatic test_hold_off;
    exp_t e;
    obs_t o;
    applyStimulus(1'b1, 6'h0F, 8'h5A, 1'b0, 6'h00, 8'h00);
    sbQ.push_back('{1'b0, 6'h0F, 8'h5A});
    captureFrame(1'b1, o);
    req0_valid = 1'b0;
    e = sbQ.pop_front();
    checks++;
    if (o.bits !== expBits(e.addr, e.data)) begin
      errors++; $display("[TB] FAIL holdoff.bits: got %h want %h", o.bits, expBits(e.addr, e.data));
    end
  endtask

  task automatic test_reset_mid;
    exp_t e;
    obs_t o;
    int   waited;
    applyStimulus(1'b1, 6'h2D, 8'hA7, 1'b0, 6'h00, 8'h00);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (req0_ready !== 1'b1 && waited < 200);
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL midreset.accept: got ready=%b want 1", req0_ready);
    end
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if (out_flow !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("[TB] FAIL midreset.addr_bit: got out=%b busy=%b want 1 1", out_flow, busy);
    end
    rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (out_flow !== 1'b0 || busy !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0 ||
        frame_done !== 1'b0 || grant_id !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset.abort: got out=%b busy=%b rdy=%b%b done=%b gid=%b, want all 0",
               out_flow, busy, req0_ready, req1_ready, frame_done, grant_id);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL midreset.pointer: got rdy0=%b rdy1=%b want 1 0", req0_ready, req1_ready);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    applyStimulus(1'b0, 6'h00, 8'h00, 1'b1, 6'h2A, 8'hC3);
    sbQ.push_back('{1'b1, 6'h2A, 8'hC3});
    captureFrame(1'b0, o);
    req1_valid = 1'b0;
    e = sbQ.pop_front();
    checks++;
    if (o.id !== e.id || o.bits !== expBits(e.addr, e.data)) begin
      errors++;
      $display("[TB] FAIL midreset.fresh_frame: got id %b bits %h want id %b bits %h",
               o.id, o.bits, e.id, expBits(e.addr, e.data));
    end
    checks++;
    if (o.doneCount !== 1 || o.bad) begin
      errors++; $display("[TB] FAIL midreset.fresh_done: got done count %0d bad %b want 1 0", o.doneCount, o.bad);
    end
  endtask

  task automatic test_contention;
    exp_t e;
    obs_t o;
    applyStimulus(1'b1, 6'h01, 8'h11, 1'b1, 6'h3E, 8'hEE);
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) sbQ.push_back('{1'b0, 6'h01, 8'h11});
      else            sbQ.push_back('{1'b1, 6'h3E, 8'hEE});
    end
    for (int i = 0; i < 4; i++) begin
      captureFrame(1'b0, o);
      e = sbQ.pop_front();
      checks++;
      if (o.id !== e.id) begin
        errors++; $display("[TB] FAIL contend.grant%0d: got %b want %b", i, o.id, e.id);
      end
      checks++;
      if (o.bits !== expBits(e.addr, e.data) || o.bad) begin
        errors++;
        $display("[TB] FAIL contend.bits%0d: got %h bad=%b want %h bad=0", i, o.bits, o.bad, expBits(e.addr, e.data));
      end
      checks++;
      if (o.waitCycles !== 1 || o.bothReady) begin
        errors++;
        $display("[TB] FAIL contend.period%0d: got wait %0d both=%b want wait 1 both=0", i, o.waitCycles, o.bothReady);
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no completion by time limit, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_single_frame();
    test_hold_off();
    test_reset_mid();
    test_contention();
    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
